// File: rtl/fifo_rd_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo_rd_packer_pkg                                      |
// | Description: Shared defaults, state encoding and lane-index helper   |
// |              for the FIFO read-side packer.                          |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package fifo_rd_packer_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // A single-bit index is kept even for degenerate ratios so vectors never collapse.
    function automatic int lane_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo_rd_packer_if                                       |
// | Description: FIFO read port plus packed output stream.               |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                             R_EMPTY;
    logic [DATA_WIDTH-1:0]            R_DATA;
    logic                             RINC;
    logic                             FLUSH;
    logic                             O_READY;
    logic                             O_VALID;
    logic [DATA_WIDTH*PACK_RATIO-1:0] O_DATA;
    logic [PACK_RATIO-1:0]            O_KEEP;
    logic [CNT_WIDTH-1:0]             O_WORD_CNT;

    // master: the packer; slave: FIFO plus downstream sink
    modport master (
        input  R_EMPTY, R_DATA, FLUSH, O_READY,
        output RINC, O_VALID, O_DATA, O_KEEP, O_WORD_CNT
    );

    modport slave (
        output R_EMPTY, R_DATA, FLUSH, O_READY,
        input  RINC, O_VALID, O_DATA, O_KEEP, O_WORD_CNT
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer_out_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo_rd_packer_out_slot                                 |
// | Description: Single output register with valid/ready hold and an    |
// |              accepted-word counter.                                  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fifo_rd_packer_out_slot #(
    parameter int WORD_WIDTH = 32,
    parameter int KEEP_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_load,
    input  wire logic [WORD_WIDTH-1:0] i_data,
    input  wire logic [KEEP_WIDTH-1:0] i_keep,
    input  wire logic                  i_ready,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [WORD_WIDTH-1:0]      o_data,
    output logic [KEEP_WIDTH-1:0]      o_keep,
    output logic [CNT_WIDTH-1:0]       o_word_cnt
);

    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic [CNT_WIDTH-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_valid && i_ready) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            // i_load is only raised while o_free, so a held word is never overwritten
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_keep  <= i_keep;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_free     = ~r_valid | i_ready;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_keep     = r_keep;
    assign o_word_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo_rd_packer                                          |
// | Description: Pops FIFO entries and packs PACK_RATIO lanes into one   |
// |              output word; FLUSH emits a masked partial word.         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic          R_CLK,
    input  wire logic          R_RST,
    fifo_rd_packer_if.master   bus
);

    localparam int LANE_BITS  = lane_bits(PACK_RATIO);
    localparam int WORD_WIDTH = DATA_WIDTH * PACK_RATIO;
    localparam logic [LANE_BITS-1:0] C_LAST_LANE = LANE_BITS'(PACK_RATIO - 1);

    state_e                r_state;
    logic [LANE_BITS-1:0]  r_idx;
    logic [WORD_WIDTH-1:0] r_acc;
    logic                  r_flush_pend;

    state_e                w_state_nxt;
    logic [LANE_BITS-1:0]  w_idx_nxt;
    logic [WORD_WIDTH-1:0] w_acc_nxt;
    logic [WORD_WIDTH-1:0] w_acc_wr;
    logic                  w_flush_nxt;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_slot_free;
    logic                  w_load;
    logic [WORD_WIDTH-1:0] w_load_data;
    logic [PACK_RATIO-1:0] w_load_keep;
    logic [PACK_RATIO-1:0] w_part_keep;

    assign w_pop    = R_RST & ~bus.R_EMPTY & (r_state == ST_FILL) & ~r_flush_pend;
    assign w_last   = w_pop & (r_idx == C_LAST_LANE);
    assign bus.RINC = w_pop;

    always_comb begin
        w_part_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            w_part_keep[i] = (i < int'(r_idx));
        end
    end

    always_comb begin
        w_acc_wr = r_acc;
        if (w_pop) begin
            w_acc_wr[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] = bus.R_DATA;
        end
    end

    always_ff @(posedge R_CLK) begin
        if (!R_RST) begin
            r_state      <= ST_FILL;
            r_idx        <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_acc        <= w_acc_nxt;
            r_flush_pend <= w_flush_nxt;
        end
    end

    // Every emission clears the accumulator so unused lanes of a partial word read as zero.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_flush_nxt = r_flush_pend;
        w_load      = 1'b0;
        w_load_data = r_acc;
        w_load_keep = '0;
        case (r_state)
            ST_FILL: begin
                if (r_flush_pend) begin
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_load_keep = w_part_keep;
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                        w_flush_nxt = 1'b0;
                    end
                end else if (w_last) begin
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_load_data = w_acc_wr;
                        w_load_keep = '1;
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                    end else begin
                        w_acc_nxt   = w_acc_wr;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (w_pop) begin
                    w_acc_nxt   = w_acc_wr;
                    w_idx_nxt   = r_idx + LANE_BITS'(1);
                    w_flush_nxt = bus.FLUSH;
                end else if (bus.FLUSH && (r_idx != '0)) begin
                    w_flush_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_keep = '1;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    fifo_rd_packer_out_slot #(
        .WORD_WIDTH (WORD_WIDTH),
        .KEEP_WIDTH (PACK_RATIO),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_out_slot (
        .clk        (R_CLK),
        .rst_n      (R_RST),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_keep     (w_load_keep),
        .i_ready    (bus.O_READY),
        .o_free     (w_slot_free),
        .o_valid    (bus.O_VALID),
        .o_data     (bus.O_DATA),
        .o_keep     (bus.O_KEEP),
        .o_word_cnt (bus.O_WORD_CNT)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_fifo_rd_packer                                       |
// | Description: Directed self-checking bench for fifo_rd_packer.        |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_fifo_rd_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4), .CNT_WIDTH(16)) if_l ();
    fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4), .CNT_WIDTH(2))  if_s ();

    assign if_s.R_EMPTY = if_l.R_EMPTY;
    assign if_s.R_DATA  = if_l.R_DATA;
    assign if_s.FLUSH   = if_l.FLUSH;
    assign if_s.O_READY = if_l.O_READY;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .CNT_WIDTH(16)) u_dut (
        .R_CLK (clk),
        .R_RST (rst),
        .bus   (if_l)
    );

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .CNT_WIDTH(2)) u_dut_small (
        .R_CLK (clk),
        .R_RST (rst),
        .bus   (if_s)
    );

    logic [7:0]  fifo_q [$];
    logic [31:0] got_d [$];
    logic [31:0] exp_d [$];
    logic [3:0]  got_k [$];
    logic [3:0]  exp_k [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int p0;
    bit last_pop;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: present FIFO head, note pop/acceptance, then consume at the edge.
    task automatic cycle(input bit gap, input bit flush);
        if_l.R_EMPTY = gap || (fifo_q.size() == 0);
        if_l.R_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        if_l.FLUSH   = flush;
        #1;
        last_pop = if_l.RINC;
        check("pop_when_empty", 64'(last_pop & if_l.R_EMPTY), 64'd0);
        if (if_l.O_VALID && if_l.O_READY) begin
            got_d.push_back(if_l.O_DATA);
            got_k.push_back(if_l.O_KEEP);
        end
        @(posedge clk);
        if (last_pop) begin
            void'(fifo_q.pop_front());
            n_pops++;
        end
        @(negedge clk);
        if_l.FLUSH = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        exp_d.push_back(d);
        exp_k.push_back(k);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_nwords"}, 64'(got_d.size()), 64'(exp_d.size()));
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            check({tag, "_data"}, 64'(got_d.pop_front()), 64'(exp_d.pop_front()));
            check({tag, "_keep"}, 64'(got_k.pop_front()), 64'(exp_k.pop_front()));
        end
        got_d.delete(); got_k.delete(); exp_d.delete(); exp_k.delete();
    endtask

    initial begin
        rst          = 1'b0;
        if_l.O_READY = 1'b0;
        if_l.FLUSH   = 1'b0;
        if_l.R_EMPTY = 1'b1;
        if_l.R_DATA  = 8'h00;
        @(negedge clk);

        // reset with a non-empty FIFO
        fifo_q.push_back(8'hAB);
        run(3);
        check("rst_rinc", 64'(last_pop), 64'd0);
        check("rst_fifo_untouched", 64'(fifo_q.size()), 64'd1);
        check("rst_valid", 64'(if_l.O_VALID), 64'd0);
        check("rst_keep", 64'(if_l.O_KEEP), 64'd0);
        check("rst_data", 64'(if_l.O_DATA), 64'd0);
        check("rst_cnt", 64'(if_l.O_WORD_CNT), 64'd0);
        fifo_q.delete();
        rst = 1'b1;

        // full word, back-to-back pops
        if_l.O_READY = 1'b1;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        p0 = n_pops;
        run(4);
        check("t2_pops", 64'(n_pops - p0), 64'd4);
        check("t2_valid", 64'(if_l.O_VALID), 64'd1);
        check("t2_data", 64'(if_l.O_DATA), 64'h44332211);
        check("t2_keep", 64'(if_l.O_KEEP), 64'hF);
        run(1);
        check("t2_cnt", 64'(if_l.O_WORD_CNT), 64'd1);
        check("t2_valid_clr", 64'(if_l.O_VALID), 64'd0);
        expect_word(32'h44332211, 4'hF);
        compare_words("t2");

        // backpressure and HOLD
        if_l.O_READY = 1'b0;
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        p0 = n_pops;
        run(4);
        check("t3_data_a", 64'(if_l.O_DATA), 64'h04030201);
        run(8);
        check("t3_data_held", 64'(if_l.O_DATA), 64'h04030201);
        check("t3_valid_held", 64'(if_l.O_VALID), 64'd1);
        check("t3_pops", 64'(n_pops - p0), 64'd8);
        check("t3_hold_rinc", 64'(last_pop), 64'd0);
        check("t3_hold_empty", 64'(if_l.R_EMPTY), 64'd0);
        if_l.O_READY = 1'b1;
        run(1);
        check("t3_hold_rinc2", 64'(last_pop), 64'd0);
        check("t3_data_b", 64'(if_l.O_DATA), 64'h08070605);
        check("t3_valid_b", 64'(if_l.O_VALID), 64'd1);
        cycle(1'b0, 1'b1);
        check("t3_flush_pop", 64'(last_pop), 64'd1);
        run(1);
        check("t3_part_data", 64'(if_l.O_DATA), 64'h00000009);
        check("t3_part_keep", 64'(if_l.O_KEEP), 64'h1);
        run(1);
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        expect_word(32'h00000009, 4'h1);
        compare_words("t3");

        // FLUSH of three lanes, then FLUSH with nothing accumulated
        fifo_q = '{8'hA1, 8'hA2, 8'hA3};
        run(3);
        cycle(1'b0, 1'b1);
        run(1);
        check("t4_valid", 64'(if_l.O_VALID), 64'd1);
        check("t4_data", 64'(if_l.O_DATA), 64'h00A3A2A1);
        check("t4_keep", 64'(if_l.O_KEEP), 64'h7);
        run(1);
        cycle(1'b0, 1'b1);
        run(2);
        check("t4_idle_valid", 64'(if_l.O_VALID), 64'd0);
        expect_word(32'h00A3A2A1, 4'h7);
        compare_words("t4");

        // R_EMPTY toggling every other cycle
        fifo_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        p0 = n_pops;
        for (int i = 0; i < 16; i++) cycle((i % 2) == 0, 1'b0);
        run(2);
        check("t5_pops", 64'(n_pops - p0), 64'd8);
        expect_word(32'hB3B2B1B0, 4'hF);
        expect_word(32'hB7B6B5B4, 4'hF);
        compare_words("t5");

        // reset mid-word, then counter wrap on the narrow counter
        fifo_q = '{8'h50, 8'h51};
        run(2);
        rst = 1'b0;
        fifo_q.push_back(8'h60);
        run(2);
        check("t6_rst_nopop", 64'(fifo_q.size()), 64'd1);
        check("t6_rst_valid", 64'(if_l.O_VALID), 64'd0);
        check("t6_rst_cnt", 64'(if_l.O_WORD_CNT), 64'd0);
        check("t6_rst_cnt_small", 64'(if_s.O_WORD_CNT), 64'd0);
        fifo_q.delete();
        rst = 1'b1;
        fifo_q = '{8'h55, 8'h56, 8'h57, 8'h58};
        run(4);
        check("t6_data", 64'(if_l.O_DATA), 64'h58575655);
        check("t6_keep", 64'(if_l.O_KEEP), 64'hF);
        for (int b = 0; b < 16; b++) fifo_q.push_back(8'(b));
        run(17);
        check("t6_cnt", 64'(if_l.O_WORD_CNT), 64'd5);
        check("t6_cnt_wrap", 64'(if_s.O_WORD_CNT), 64'd1);
        expect_word(32'h58575655, 4'hF);
        expect_word(32'h03020100, 4'hF);
        expect_word(32'h07060504, 4'hF);
        expect_word(32'h0B0A0908, 4'hF);
        expect_word(32'h0F0E0D0C, 4'hF);
        compare_words("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
